// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port maze map memory between the map
// loader (0), solver (1) and path scanner (2). One IDLE/ISSUE/RESP transaction at a time.
module maze_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              req2,
  input  logic              rw0,
  input  logic              rw1,
  input  logic              rw2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              lock2,
  output logic              ack0,
  output logic              ack1,
  output logic              ack2,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] NO_GRANT = 2'd3;

  state_t            state, state_nxt;
  logic [1:0]        rr_ptr, rr_nxt;
  logic              locked, locked_nxt;
  logic [1:0]        grant_nxt;
  logic              rw_q, rw_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  logic [2:0]        req_v, rw_v, lock_v;
  logic [ADDR_W-1:0] addr_v  [3];
  logic [DATA_W-1:0] wdata_v [3];

  logic [1:0]        cand0, cand1, cand2;
  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic              take;
  logic [1:0]        take_idx;

  assign req_v  = {req2, req1, req0};
  assign rw_v   = {rw2, rw1, rw0};
  assign lock_v = {lock2, lock1, lock0};

  assign addr_v[0]  = addr0;
  assign addr_v[1]  = addr1;
  assign addr_v[2]  = addr2;
  assign wdata_v[0] = wdata0;
  assign wdata_v[1] = wdata1;
  assign wdata_v[2] = wdata2;

  function automatic logic [1:0] rr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order starts at the round-robin pointer and wraps modulo 3.
  assign cand0 = rr_ptr;
  assign cand1 = rr_inc(cand0);
  assign cand2 = rr_inc(cand1);

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = cand0;
    if (req_v[cand0]) begin
      pick_valid = 1'b1;
      pick_idx   = cand0;
    end else if (req_v[cand1]) begin
      pick_valid = 1'b1;
      pick_idx   = cand1;
    end else if (req_v[cand2]) begin
      pick_valid = 1'b1;
      pick_idx   = cand2;
    end
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    locked_nxt = locked;
    grant_nxt  = grant;
    rw_nxt     = rw_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    rdata_nxt  = rdata_q;
    take       = 1'b0;
    take_idx   = grant;

    unique case (state)
      IDLE: begin
        if (locked) begin
          // While locked, grant already holds the owner and only it may proceed.
          if (req_v[grant]) begin
            take     = 1'b1;
            take_idx = grant;
          end
        end else if (pick_valid) begin
          take     = 1'b1;
          take_idx = pick_idx;
        end else begin
          grant_nxt = NO_GRANT;
        end
        if (take) begin
          state_nxt = ISSUE;
          grant_nxt = take_idx;
          rw_nxt    = rw_v[take_idx];
          addr_nxt  = addr_v[take_idx];
          wdata_nxt = wdata_v[take_idx];
        end
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        state_nxt  = IDLE;
        locked_nxt = lock_v[grant];
        if (!rw_q) rdata_nxt = mem_dout;
        if (!lock_v[grant]) begin
          rr_nxt    = rr_inc(grant);
          grant_nxt = NO_GRANT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= 2'd0;
      locked  <= 1'b0;
      grant   <= NO_GRANT;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_nxt;
      locked  <= locked_nxt;
      grant   <= grant_nxt;
      rw_q    <= rw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  // Outputs decode registered state only; read data passes straight through during RESP.
  assign busy     = (state != IDLE);
  assign mem_rd   = (state == ISSUE) && !rw_q;
  assign mem_wr   = (state == ISSUE) && rw_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign ack0     = (state == RESP) && (grant == 2'd0);
  assign ack1     = (state == RESP) && (grant == 2'd1);
  assign ack2     = (state == RESP) && (grant == 2'd2);
  assign rdata    = ((state == RESP) && !rw_q) ? mem_dout : rdata_q;

endmodule
